// File: rtl/udp_tx_scheduler.sv
// rtl/udp_tx_scheduler.sv - round-robin whole-packet scheduler in front of udp_send
module udp_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_length,
  input  logic [8*NUM_REQ-1:0]  req_port_ID,
  input  logic [8*NUM_REQ-1:0]  req_data,
  input  logic                  udp_active,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    rd_strobe,
  output logic                  tx_enable,
  output logic [15:0]           length_in,
  output logic [7:0]            port_ID,
  output logic [7:0]            data_out,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_DRAIN, S_GAP} state_t;

  // With no gap configured a finished packet returns straight to arbitration.
  localparam state_t POST_STATE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t             state_q, state_d;
  logic [LW-1:0]      lane_q, rr_ptr_q, pick;
  logic               pick_valid;
  logic [15:0]        len_q, cnt_q, pick_len;
  logic [7:0]         port_q, pick_port, data_sel;
  logic [GW-1:0]      gap_q;
  logic [NUM_REQ-1:0] lane_onehot;

  assign lane_onehot = NUM_REQ'(1) << lane_q;

  // Round-robin pick: first requester above rr_ptr, else first at or below it.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    pick_len   = '0;
    pick_port  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && req[i] && (LW'(i) > rr_ptr_q)) begin
        pick       = LW'(i);
        pick_valid = 1'b1;
        pick_len   = req_length[16*i +: 16];
        pick_port  = req_port_ID[8*i +: 8];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && req[i] && (LW'(i) <= rr_ptr_q)) begin
        pick       = LW'(i);
        pick_valid = 1'b1;
        pick_len   = req_length[16*i +: 16];
        pick_port  = req_port_ID[8*i +: 8];
      end
    end
  end

  // Show-ahead byte of the owning lane.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lane_q == LW'(i)) data_sel = req_data[8*i +: 8];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and udp_send-facing outputs.
  always_comb begin
    state_d   = state_q;
    grant     = '0;
    rd_strobe = '0;
    tx_enable = 1'b0;
    length_in = '0;
    port_ID   = '0;
    data_out  = '0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_LOAD;
      S_LOAD:  state_d = (len_q == 16'd0) ? POST_STATE : S_SEND;
      S_SEND:  if (cnt_q == 16'd0) state_d = S_DRAIN;
      S_DRAIN: if (!udp_active) state_d = POST_STATE;
      S_GAP:   if (gap_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_LOAD || state_q == S_SEND || state_q == S_DRAIN) begin
      grant     = lane_onehot;
      length_in = len_q;
      port_ID   = port_q;
      data_out  = data_sel;
    end
    if (state_q == S_SEND) begin
      tx_enable = 1'b1;
      rd_strobe = lane_onehot;
    end
  end

  // Packet latch, byte/gap counters, rr pointer and zero-length error count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q    <= '0;
      rr_ptr_q  <= LW'(NUM_REQ - 1);
      len_q     <= '0;
      port_q    <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      err_count <= '0;
    end else begin
      if (state_q == S_IDLE && pick_valid) begin
        lane_q <= pick;
        len_q  <= pick_len;
        port_q <= pick_port;
      end
      if (state_q == S_LOAD) begin
        rr_ptr_q <= lane_q;
        if (len_q == 16'd0) begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          cnt_q <= len_q - 16'd1;
        end
      end
      if (state_q == S_SEND && cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
      if (state_d == S_GAP && state_q != S_GAP) gap_q <= GW'(GAP_CYCLES - 1);
      else if (state_q == S_GAP)                gap_q <= gap_q - GW'(1);
    end
  end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb/tb_udp_tx_scheduler.sv - scoreboard bench for udp_tx_scheduler
module tb_udp_tx_scheduler;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]    req;
  logic [16*N-1:0] req_length;
  logic [8*N-1:0]  req_port_ID, req_data;
  logic            udp_active = 1'b0;
  logic [N-1:0]    grant, rd_strobe;
  logic            tx_enable, busy;
  logic [15:0]     length_in;
  logic [7:0]      port_ID, data_out, err_count;

  logic [N-1:0]    req0 = '0;
  logic [8*N-1:0]  req_data0 = '0;
  logic            udp_active0 = 1'b0;
  logic [N-1:0]    grant0, rd_strobe0;
  logic            tx_enable0, busy0;
  logic [15:0]     length_in0;
  logic [7:0]      port_ID0, data_out0, err_count0;

  udp_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(12)) u_dut (
    .clock(clock), .reset(reset), .req(req), .req_length(req_length),
    .req_port_ID(req_port_ID), .req_data(req_data), .udp_active(udp_active),
    .grant(grant), .rd_strobe(rd_strobe), .tx_enable(tx_enable),
    .length_in(length_in), .port_ID(port_ID), .data_out(data_out),
    .busy(busy), .err_count(err_count));

  udp_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset), .req(req0), .req_length({48'd0, 16'd1}),
    .req_port_ID(32'h0000_0007), .req_data(req_data0), .udp_active(udp_active0),
    .grant(grant0), .rd_strobe(rd_strobe0), .tx_enable(tx_enable0),
    .length_in(length_in0), .port_ID(port_ID0), .data_out(data_out0),
    .busy(busy0), .err_count(err_count0));

  typedef struct {
    logic [3:0]  oh;
    logic [7:0]  data;
    logic [15:0] len;
    logic [7:0]  port;
  } beat_t;

  beat_t       exp_beat[$];
  int          exp_grant[$];
  logic [15:0] len_cfg[N];
  logic [7:0]  port_cfg[N];
  int          pkts_left[N];
  int          ptr[N];
  int          exp_ptr[N];
  int          extra_hold = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [7:0] src_byte(input int lane, input int k);
    return 8'(16 * lane + (k % 16));
  endfunction

  always_comb begin
    req = '0; req_length = '0; req_port_ID = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin
      req[i]                = (pkts_left[i] != 0);
      req_length[16*i +: 16] = len_cfg[i];
      req_port_ID[8*i +: 8]  = port_cfg[i];
      req_data[8*i +: 8]     = src_byte(i, ptr[i]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return tx_enable;
      1: return udp_active;
      2: return busy;
      3: return |grant;
      4: return |grant0;
      5: return busy0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input string name, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (sig(which) != val && n < 3000);
    if (sig(which) != val) check({name, "_timeout"}, 32'(sig(which)), 32'(val));
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_grant.size() != 0 || exp_beat.size() != 0 || busy) && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check({name, "_drained"}, 32'(k < 3000), 1);
  endtask

  task automatic push_pkt(input int lane);
    beat_t b;
    exp_grant.push_back(lane);
    for (int k = 0; k < int'(len_cfg[lane]); k++) begin
      b.oh   = 4'(1 << lane);
      b.data = src_byte(lane, exp_ptr[lane]);
      b.len  = len_cfg[lane];
      b.port = port_cfg[lane];
      exp_beat.push_back(b);
      exp_ptr[lane]++;
    end
  endtask

  task automatic flush();
    exp_grant.delete();
    exp_beat.delete();
    extra_hold = 0;
    for (int i = 0; i < N; i++) begin
      ptr[i] = 0; exp_ptr[i] = 0; pkts_left[i] = 0;
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b0;
    flush();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // udp_send stand-in: active from first byte until 8 header clocks (+extra) after the last.
  initial begin : udp_model
    logic t;
    int   tail;
    tail = 0;
    forever begin
      @(negedge clock);
      t = tx_enable;
      #1;
      if (!reset) begin
        udp_active = 1'b0; tail = 0;
      end else if (t) begin
        udp_active = 1'b1; tail = 8 + extra_hold;
      end else if (udp_active) begin
        if (tail == 0) udp_active = 1'b0;
        else tail--;
      end
    end
  end

  // Packet FIFOs: a packet is popped at grant, a byte advances on the clock after each strobe.
  initial begin : sources
    logic [N-1:0] g, pg, sseen;
    pg = '0;
    forever begin
      @(negedge clock);
      g = grant;
      sseen = rd_strobe;
      if (g != '0 && pg == '0)
        for (int i = 0; i < N; i++) if (g[i] && pkts_left[i] > 0) pkts_left[i]--;
      pg = g;
      @(posedge clock);
      #1;
      if (reset) for (int i = 0; i < N; i++) if (sseen[i]) ptr[i]++;
    end
  end

  // Scoreboard monitor: checks every new grant and every transmitted byte.
  initial begin : monitor
    logic [N-1:0] prev_g;
    beat_t        b;
    int           gl;
    prev_g = '0;
    forever begin
      @(negedge clock);
      if (grant != '0 && prev_g == '0) begin
        if (exp_grant.size() == 0) check("grant_unexpected", 32'(grant), 0);
        else begin
          gl = exp_grant.pop_front();
          check("grant_lane", 32'(grant), 32'(1 << gl));
        end
      end
      prev_g = grant;
      if (tx_enable) begin
        if (exp_beat.size() == 0) check("beat_unexpected", 32'(tx_enable), 0);
        else begin
          b = exp_beat.pop_front();
          check("beat_strobe", 32'(rd_strobe), 32'(b.oh));
          check("beat_grant", 32'(grant), 32'(b.oh));
          check("beat_data", 32'(data_out), 32'(b.data));
          check("beat_len", 32'(length_in), 32'(b.len));
          check("beat_port", 32'(port_ID), 32'(b.port));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n, k, cnt, bad;
    for (int i = 0; i < N; i++) begin
      len_cfg[i] = 16'd0; port_cfg[i] = 8'd0;
    end
    flush();
    repeat (2) @(negedge clock);
    check("rst_grant", 32'(grant), 0);
    check("rst_outputs", 32'({rd_strobe, tx_enable, busy, data_out}), 0);
    check("rst_len_port", 32'({length_in, port_ID}), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_dut0", 32'({grant0, tx_enable0, busy0}), 0);
    reset = 1'b1;

    // 1: single lane-2 packet, latency and gap timing
    reset_dut();
    len_cfg[2] = 16'd4; port_cfg[2] = 8'd3;
    push_pkt(2);
    pkts_left[2] = 1;
    @(negedge clock);
    check("t1_grant_n1", 32'(grant), 4);
    check("t1_tx_n1", 32'(tx_enable), 0);
    check("t1_len_n1", 32'(length_in), 4);
    check("t1_port_n1", 32'(port_ID), 3);
    @(negedge clock);
    check("t1_tx_n2", 32'(tx_enable), 1);
    wait_for(0, 1'b0, "t1_txend", n);
    wait_for(1, 1'b0, "t1_fall", n);
    check("t1_grant_gap", 32'(grant), 0);
    wait_for(2, 1'b0, "t1_idle", n);
    check("t1_gap_len", n, 12);
    wait_drain("t1");

    // 2: all four requesting, round-robin order 0,1,2,3,0,1
    reset_dut();
    for (int i = 0; i < N; i++) begin
      len_cfg[i] = 16'd2; port_cfg[i] = 8'(8 + i);
    end
    push_pkt(0); push_pkt(1); push_pkt(2); push_pkt(3); push_pkt(0); push_pkt(1);
    pkts_left[0] = 2; pkts_left[1] = 2; pkts_left[2] = 1; pkts_left[3] = 1;
    wait_drain("t2");

    // 3: zero-length lane 1 is rejected, lane 3 then sends 8 bytes
    reset_dut();
    len_cfg[1] = 16'd0; port_cfg[1] = 8'd2;
    len_cfg[3] = 16'd8; port_cfg[3] = 8'd4;
    push_pkt(1); push_pkt(3);
    pkts_left[1] = 1; pkts_left[3] = 1;
    @(negedge clock);
    check("t3_grant1", 32'(grant), 2);
    check("t3_tx_load", 32'(tx_enable), 0);
    @(negedge clock);
    check("t3_grant_clr", 32'(grant), 0);
    check("t3_tx_none", 32'(tx_enable), 0);
    check("t3_err1", 32'(err_count), 1);
    wait_drain("t3");
    check("t3_err_end", 32'(err_count), 1);

    // 4: reset at 3rd byte of 10, then lane 0 wins first
    reset_dut();
    len_cfg[2] = 16'd10; port_cfg[2] = 8'd5;
    push_pkt(2);
    pkts_left[2] = 1;
    k = 0; cnt = 0;
    while (cnt < 3 && k < 200) begin
      @(negedge clock);
      k++;
      if (tx_enable) cnt++;
    end
    check("t4_byte3", cnt, 3);
    #2 reset = 1'b0;
    #1;
    check("t4_abort_grant", 32'({grant, rd_strobe}), 0);
    check("t4_abort_tx", 32'({tx_enable, busy, data_out}), 0);
    check("t4_abort_lenport", 32'({length_in, port_ID}), 0);
    flush();
    len_cfg[0] = 16'd3; port_cfg[0] = 8'd1;
    len_cfg[3] = 16'd2; port_cfg[3] = 8'd6;
    push_pkt(0); push_pkt(3);
    pkts_left[0] = 1; pkts_left[3] = 1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_drain("t4");

    // 5: udp_active held 20 extra clocks holds off the next grant
    reset_dut();
    extra_hold = 20;
    len_cfg[0] = 16'd2; port_cfg[0] = 8'd9;
    len_cfg[1] = 16'd1; port_cfg[1] = 8'd6;
    push_pkt(0); push_pkt(1);
    pkts_left[0] = 1; pkts_left[1] = 1;
    wait_for(0, 1'b1, "t5_tx", n);
    wait_for(0, 1'b0, "t5_txend", n);
    k = 0; bad = 0;
    while (udp_active && k < 200) begin
      if (grant != 4'b0001 || tx_enable) bad++;
      @(negedge clock);
      k++;
    end
    check("t5_drain_hold", bad, 0);
    check("t5_drain_long", 32'(k >= 20), 1);
    check("t5_grant_gap", 32'(grant), 0);
    wait_for(3, 1'b1, "t5_next", n);
    check("t5_fall_to_grant", n, 13);
    wait_drain("t5");

    // 6: GAP_CYCLES=0 instance, lane 0 len 1 twice, bytes A5 then 5A
    reset_dut();
    req_data0 = 32'h0000_00A5;
    req0 = 4'b0001;
    for (int p = 0; p < 2; p++) begin
      wait_for(4, 1'b1, "t6_grant", n);
      check("t6_grant_lat", n, (p == 0) ? 1 : 2);
      check("t6_grant", 32'(grant0), 1);
      check("t6_load_tx", 32'(tx_enable0), 0);
      check("t6_len_port", 32'({length_in0, port_ID0}), 32'h0001_07);
      if (p == 1) req0 = 4'b0000;
      @(negedge clock);
      check("t6_tx", 32'({tx_enable0, rd_strobe0}), 5'b1_0001);
      check("t6_data", 32'(data_out0), (p == 0) ? 32'hA5 : 32'h5A);
      #1 udp_active0 = 1'b1;
      @(posedge clock);
      #1 req_data0 = 32'h0000_005A;
      @(negedge clock);
      check("t6_single", 32'({tx_enable0, grant0}), 1);
      repeat (7) @(negedge clock);
      #1 udp_active0 = 1'b0;
    end
    wait_for(5, 1'b0, "t6_idle", n);
    check("t6_err", 32'(err_count0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
